// File: rtl/flappy_pkg.sv
// Shared types for the flappy-bird collision logic: hit causes, FSM states
// and the hit_idx width helper.
package flappy_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_WALL = 2'd1,
      CAUSE_PIPE = 2'd2
   } hit_cause_t;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_GRACE = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipe_hit_check.sv
// Combinational overlap test of the bird against one pipe pair.
// Geometry is evaluated with two extra bits, signed, so left/top edges clamp at 0.
module pipe_hit_check #(
   parameter int COORD_W = 11,
   parameter int PIPE_W  = 70,
   parameter int GAP     = 80,
   parameter int TOP_M   = 7,
   parameter int BOT_M   = 5
) (
   input  logic [COORD_W-1:0] bird_x,
   input  logic [COORD_W-1:0] bird_y,
   input  logic [COORD_W-1:0] pipe_x,
   input  logic [COORD_W-1:0] pipe_y,
   output logic               hit
);

   localparam int SW = COORD_W + 2;
   localparam logic signed [SW-1:0] PW_S   = SW'(PIPE_W);
   localparam logic signed [SW-1:0] GAP_S  = SW'(GAP);
   localparam logic signed [SW-1:0] TOPM_S = SW'(TOP_M);
   localparam logic signed [SW-1:0] BOTM_S = SW'(BOT_M);

   logic signed [SW-1:0] bx_s, by_s, px_s, py_s;
   logic signed [SW-1:0] left_s, lo_s, hi_s;
   logic signed [SW-1:0] left_c, lo_c, hi_c;
   logic                 in_x, safe_y;

   always_comb begin
      bx_s   = $signed({2'b00, bird_x});
      by_s   = $signed({2'b00, bird_y});
      px_s   = $signed({2'b00, pipe_x});
      py_s   = $signed({2'b00, pipe_y});
      left_s = px_s - PW_S;
      lo_s   = py_s - GAP_S + TOPM_S;
      hi_s   = py_s - BOTM_S;
      left_c = left_s[SW-1] ? '0 : left_s;
      lo_c   = lo_s[SW-1]   ? '0 : lo_s;
      hi_c   = hi_s[SW-1]   ? '0 : hi_s;
      in_x   = (bx_s >= left_c) && (bx_s <= px_s);
      safe_y = (by_s > lo_c) && (by_s < hi_c);
      hit    = in_x && !safe_y;
   end

endmodule

// File: rtl/bird_collision_fsm.sv
// Collision and lives manager: wall check, pipe priority encoder, and the
// PLAY/GRACE/DEAD FSM with lives and grace-frame counters.
module bird_collision_fsm
   import flappy_pkg::*;
#(
   parameter int N_PIPES      = 2,
   parameter int COORD_W      = 11,
   parameter int PIPE_W       = 70,
   parameter int GAP          = 80,
   parameter int TOP_M        = 7,
   parameter int BOT_M        = 5,
   parameter int Y_MIN        = 11,
   parameter int Y_MAX        = 474,
   parameter int LIVES        = 3,
   parameter int GRACE_FRAMES = 60
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            frame_tick,
   input  logic                            restart,
   input  logic [COORD_W-1:0]              bird_x,
   input  logic [COORD_W-1:0]              bird_y,
   input  logic [N_PIPES*COORD_W-1:0]      pipe_x,
   input  logic [N_PIPES*COORD_W-1:0]      pipe_y,
   output logic                            collision,
   output logic                            hit_pulse,
   output logic [2:0]                      lives,
   output logic                            invuln,
   output logic [1:0]                      hit_cause,
   output logic [idx_width(N_PIPES)-1:0]   hit_idx
);

   localparam int IDX_W = idx_width(N_PIPES);
   localparam int GC_W  = $clog2(GRACE_FRAMES + 1);

   logic [N_PIPES-1:0] pipe_hit;
   logic               pipe_any, wall_hit;
   logic [IDX_W-1:0]   pipe_idx;

   state_t           state_q, state_d;
   logic [2:0]       lives_q, lives_d;
   logic [GC_W-1:0]  grace_q, grace_d;
   hit_cause_t       cause_q, cause_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pulse_q, pulse_d;

   for (genvar g = 0; g < N_PIPES; g++) begin : g_pipe
      pipe_hit_check #(
         .COORD_W (COORD_W),
         .PIPE_W  (PIPE_W),
         .GAP     (GAP),
         .TOP_M   (TOP_M),
         .BOT_M   (BOT_M)
      ) u_chk (
         .bird_x (bird_x),
         .bird_y (bird_y),
         .pipe_x (pipe_x[g*COORD_W +: COORD_W]),
         .pipe_y (pipe_y[g*COORD_W +: COORD_W]),
         .hit    (pipe_hit[g])
      );
   end

   // Descending scan so the lowest hitting index is the last one written.
   always_comb begin
      pipe_any = 1'b0;
      pipe_idx = '0;
      for (int unsigned i = N_PIPES; i > 0; i--) begin
         if (pipe_hit[i-1]) begin
            pipe_any = 1'b1;
            pipe_idx = IDX_W'(i - 1);
         end
      end
      wall_hit = (bird_y < COORD_W'(Y_MIN)) || (bird_y > COORD_W'(Y_MAX));
   end

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      grace_d = grace_q;
      cause_d = cause_q;
      idx_d   = idx_q;
      pulse_d = 1'b0;
      if (restart) begin
         state_d = ST_PLAY;
         lives_d = 3'(LIVES);
         grace_d = '0;
         cause_d = CAUSE_NONE;
         idx_d   = '0;
      end else if (frame_tick) begin
         unique case (state_q)
            ST_PLAY: begin
               if (wall_hit || pipe_any) begin
                  lives_d = lives_q - 3'd1;
                  pulse_d = 1'b1;
                  cause_d = wall_hit ? CAUSE_WALL : CAUSE_PIPE;
                  if (!wall_hit) idx_d = pipe_idx;
                  if (lives_q == 3'd1) begin
                     state_d = ST_DEAD;
                  end else begin
                     grace_d = GC_W'(GRACE_FRAMES);
                     state_d = ST_GRACE;
                  end
               end
            end
            ST_GRACE: begin
               grace_d = grace_q - GC_W'(1);
               if (grace_q == GC_W'(1)) state_d = ST_PLAY;
            end
            ST_DEAD:  lives_d = '0;
            default:  state_d = ST_PLAY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_PLAY;
         lives_q <= 3'(LIVES);
         grace_q <= '0;
         cause_q <= CAUSE_NONE;
         idx_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         grace_q <= grace_d;
         cause_q <= cause_d;
         idx_q   <= idx_d;
         pulse_q <= pulse_d;
      end
   end

   assign collision = (state_q == ST_DEAD);
   assign invuln    = (state_q == ST_GRACE);
   assign hit_pulse = pulse_q;
   assign lives     = lives_q;
   assign hit_cause = cause_q;
   assign hit_idx   = idx_q;

endmodule

// File: tb/tb_bird_collision_fsm.sv
// Table-driven scoreboard bench for bird_collision_fsm with a short grace window.
module tb_bird_collision_fsm;

   localparam int W = 11;
   localparam logic [1:0] CN = 2'd0, CW = 2'd1, CP = 2'd2;

   typedef struct {
      logic         rst, rs, tk;
      logic [W-1:0] bx, by, p0x, p0y, p1x, p1y;
      logic         pulse;
      logic [2:0]   lives;
      logic         coll, inv;
      logic [1:0]   cause;
      logic         idx;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1, frame_tick = 1'b0, restart = 1'b0;
   logic [W-1:0]   bird_x = '0, bird_y = '0;
   logic [2*W-1:0] pipe_x = '0, pipe_y = '0;
   logic           collision, hit_pulse, invuln;
   logic [2:0]     lives;
   logic [1:0]     hit_cause;
   logic [0:0]     hit_idx;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   bird_collision_fsm #(.N_PIPES(2), .COORD_W(W), .LIVES(3), .GRACE_FRAMES(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .restart    (restart),
      .bird_x     (bird_x),
      .bird_y     (bird_y),
      .pipe_x     (pipe_x),
      .pipe_y     (pipe_y),
      .collision  (collision),
      .hit_pulse  (hit_pulse),
      .lives      (lives),
      .invuln     (invuln),
      .hit_cause  (hit_cause),
      .hit_idx    (hit_idx)
   );

   function automatic vec_t mk(input logic rst, rs, tk, input int bx, by, p0x, p0y, p1x, p1y,
                               input logic pulse, input int lv, input logic coll, inv,
                               input logic [1:0] cause, input logic idx);
      vec_t v;
      v.rst = rst; v.rs = rs; v.tk = tk;
      v.bx = W'(bx); v.by = W'(by);
      v.p0x = W'(p0x); v.p0y = W'(p0y); v.p1x = W'(p1x); v.p1y = W'(p1y);
      v.pulse = pulse; v.lives = 3'(lv); v.coll = coll; v.inv = inv;
      v.cause = cause; v.idx = idx;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp, input int vn);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, vn, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int vn);
      vec_t e;
      @(negedge clk);
      reset = v.rst; restart = v.rs; frame_tick = v.tk;
      bird_x = v.bx; bird_y = v.by;
      pipe_x = {v.p1x, v.p0x}; pipe_y = {v.p1y, v.p0y};
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("hit_pulse", int'(hit_pulse), int'(e.pulse), vn);
      chk("lives",     int'(lives),     int'(e.lives), vn);
      chk("collision", int'(collision), int'(e.coll),  vn);
      chk("invuln",    int'(invuln),    int'(e.inv),   vn);
      chk("hit_cause", int'(hit_cause), int'(e.cause), vn);
      chk("hit_idx",   int'(hit_idx),   int'(e.idx),   vn);
   endtask

   initial begin
      // reset state
      tbl.push_back(mk(1,0,0, 100,50, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(1,0,0, 100,50, 200,300, 600,300, 0,3,0,0,CN,0));
      // sweep toward pipe0; x range is [130,200], safe window (227,295)
      for (int bx = 100; bx <= 125; bx += 5)
         tbl.push_back(mk(0,0,1, bx,50, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 129,50, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 130,50, 200,300, 600,300, 1,2,0,1,CP,0));
      tbl.push_back(mk(0,0,1, 140,50, 200,300, 600,300, 0,2,0,1,CP,0));
      tbl.push_back(mk(0,0,0, 140,50, 200,300, 600,300, 0,2,0,1,CP,0));
      tbl.push_back(mk(0,0,1, 140,50, 200,300, 600,300, 0,2,0,1,CP,0));
      tbl.push_back(mk(0,0,1, 140,50, 200,300, 600,300, 0,2,0,0,CP,0));
      tbl.push_back(mk(0,0,1, 140,50, 200,300, 600,300, 1,1,0,1,CP,0));
      tbl.push_back(mk(0,0,1, 100,50, 200,300, 600,300, 0,1,0,1,CP,0));
      tbl.push_back(mk(0,0,1, 100,50, 200,300, 600,300, 0,1,0,1,CP,0));
      tbl.push_back(mk(0,0,1, 100,50, 200,300, 600,300, 0,1,0,0,CP,0));
      // fatal wall hit, then DEAD holds
      tbl.push_back(mk(0,0,1, 100,475, 200,300, 600,300, 1,0,1,0,CW,0));
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(0,0,1, 100,475, 200,300, 600,300, 0,0,1,0,CW,0));
      // restart beats a hitting tick
      tbl.push_back(mk(0,1,1, 130,50, 200,300, 600,300, 0,3,0,0,CN,0));
      // wall and window boundaries
      tbl.push_back(mk(0,0,1, 100,11,  200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 100,474, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 130,228, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 130,294, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 200,295, 200,300, 600,300, 1,2,0,1,CP,0));
      tbl.push_back(mk(0,1,0, 200,295, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 130,227, 200,300, 600,300, 1,2,0,1,CP,0));
      tbl.push_back(mk(0,1,0, 130,227, 200,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 201,50,  200,300, 600,300, 0,3,0,0,CN,0));
      // both pipes overlapping: WALL over PIPE, lowest index wins
      tbl.push_back(mk(0,0,1, 180,5,  200,300, 210,300, 1,2,0,1,CW,0));
      tbl.push_back(mk(0,1,0, 180,5,  200,300, 210,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 180,50, 200,300, 210,300, 1,2,0,1,CP,0));
      tbl.push_back(mk(0,1,0, 180,50, 200,300, 210,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 180,50, 600,300, 200,300, 1,2,0,1,CP,1));
      tbl.push_back(mk(0,0,1, 180,5,  600,300, 200,300, 0,2,0,1,CP,1));
      tbl.push_back(mk(0,1,0, 180,5,  600,300, 200,300, 0,3,0,0,CN,0));
      // left edge clamps to 0
      tbl.push_back(mk(0,0,1, 0,50,  30,300, 600,300, 1,2,0,1,CP,0));
      tbl.push_back(mk(0,1,0, 0,50,  30,300, 600,300, 0,3,0,0,CN,0));
      tbl.push_back(mk(0,0,1, 31,50, 30,300, 600,300, 0,3,0,0,CN,0));

      foreach (tbl[i]) step(tbl[i], i);

      // reset coinciding with a hitting tick while in GRACE
      step(mk(0,0,1, 130,50, 200,300, 600,300, 1,2,0,1,CP,0), 1000);
      step(mk(1,0,1, 130,50, 200,300, 600,300, 0,3,0,0,CN,0), 1001);
      step(mk(0,0,1, 100,50, 200,300, 600,300, 0,3,0,0,CN,0), 1002);
      // restart aborts grace immediately, next hit counts again
      step(mk(0,0,1, 130,50, 200,300, 600,300, 1,2,0,1,CP,0), 1003);
      step(mk(0,1,0, 130,50, 200,300, 600,300, 0,3,0,0,CN,0), 1004);
      step(mk(0,0,1, 130,50, 200,300, 600,300, 1,2,0,1,CP,0), 1005);

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: got %0d left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
